uart_receiver: RTL

- Asynchronous serial receiver. It is the receive-side counterpart of the team's UART transmitter and uses the same line-format controls.
- Synchronises the `rx` line, detects and validates start bits, samples 5–8 data bits LSB-first at mid-bit, then checks optional parity and 1 or 2 stop bits.
- Presents each received character in a holding register with a valid/ack handshake, plus per-character error flags and an overrun pulse.

---
 rtl/uart_receiver.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// Asynchronous serial receiver: synchronises rx, validates the start bit, samples 5-8 data bits
// LSB-first at mid-bit, checks optional parity and 1-2 stop bits, and holds each character for a valid/ack handshake.
module uart_receiver #(
    parameter int CLOCK_DIVISOR_WIDTH = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rx,
    input  logic [1:0]                     dataBits,
    input  logic                           hasParity,
    input  logic [1:0]                     parityMode,
    input  logic                           extraStopBit,
    input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
    output logic                           busy,
    output logic [7:0]                     data,
    output logic                           dataValid,
    input  logic                           dataAck,
    output logic                           parityError,
    output logic                           frameError,
    output logic                           overrun
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP1 = 3'd4;
    localparam logic [2:0] STOP2 = 3'd5;
    localparam logic [2:0] DONE  = 3'd6;

    logic [2:0]                     state;
    logic                           rxMeta;
    logic                           rxSync;
    logic                           rxPrev;
    logic                           fallingEdge;
    logic [CLOCK_DIVISOR_WIDTH:0]   bitCounter;
    logic [CLOCK_DIVISOR_WIDTH:0]   sampleTarget;
    logic                           sampleNow;
    logic [2:0]                     remaining;
    logic [2:0]                     bitIndex;
    logic [7:0]                     shiftReg;
    logic                           parityErrPend;
    logic                           frameErrPend;
    logic                           expectedParity;
    logic [1:0]                     cfgDataBits;
    logic                           cfgHasParity;
    logic [1:0]                     cfgParityMode;
    logic                           cfgExtraStopBit;
    logic [CLOCK_DIVISOR_WIDTH-1:0] cfgDivisor;

    // Flops reset to the idle level so a line already low when reset releases still yields a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxPrev <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
            rxPrev <= rxSync;
        end
    end

    assign fallingEdge = rxPrev & ~rxSync;
    assign busy        = state != IDLE;

    // The start bit is sampled half a bit in; every later sample lands one full bit (2*div+2) after the previous.
    assign sampleTarget = (state == START) ? {1'b0, cfgDivisor} : {cfgDivisor, 1'b1};
    assign sampleNow    = (state != IDLE) && (state != DONE) && (bitCounter == sampleTarget);
    assign bitIndex     = {1'b0, cfgDataBits} + 3'd4 - remaining;

    always_comb begin
        // NOTE: the default ahead of the case keeps every path assigned, so no latch is inferred.
        expectedParity = 1'b0;
        case (cfgParityMode)
            2'b11:   expectedParity = 1'b1;
            2'b10:   expectedParity = ^shiftReg;
            2'b01:   expectedParity = ~^shiftReg;
            default: expectedParity = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            bitCounter      <= '0;
            remaining       <= '0;
            shiftReg        <= '0;
            parityErrPend   <= 1'b0;
            frameErrPend    <= 1'b0;
            cfgDataBits     <= '0;
            cfgHasParity    <= 1'b0;
            cfgParityMode   <= '0;
            cfgExtraStopBit <= 1'b0;
            cfgDivisor      <= '0;
            data            <= '0;
            dataValid       <= 1'b0;
            parityError     <= 1'b0;
            frameError      <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every decision in this edge sees pre-edge register values.
            overrun <= 1'b0;
            if (dataAck && dataValid)
                dataValid <= 1'b0;

            if (state == IDLE || state == DONE || sampleNow)
                bitCounter <= '0;
            else
                bitCounter <= bitCounter + {{CLOCK_DIVISOR_WIDTH{1'b0}}, 1'b1};

            case (state)
                IDLE: begin
                    if (fallingEdge) begin
                        cfgDataBits     <= dataBits;
                        cfgHasParity    <= hasParity;
                        cfgParityMode   <= parityMode;
                        cfgExtraStopBit <= extraStopBit;
                        cfgDivisor      <= clockDivisor;
                        shiftReg        <= '0;
                        parityErrPend   <= 1'b0;
                        frameErrPend    <= 1'b0;
                        state           <= START;
                    end
                end
                START: begin
                    if (sampleNow) begin
                        if (rxSync) begin
                            state <= IDLE;
                        end else begin
                            remaining <= {1'b0, cfgDataBits} + 3'd4;
                            state     <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (sampleNow) begin
                        shiftReg[bitIndex] <= rxSync;
                        if (remaining == 3'd0)
                            state <= cfgHasParity ? PAR : STOP1;
                        else
                            remaining <= remaining - 3'd1;
                    end
                end
                PAR: begin
                    if (sampleNow) begin
                        parityErrPend <= rxSync != expectedParity;
                        state         <= STOP1;
                    end
                end
                STOP1: begin
                    if (sampleNow) begin
                        if (!rxSync)
                            frameErrPend <= 1'b1;
                        state <= cfgExtraStopBit ? STOP2 : DONE;
                    end
                end
                STOP2: begin
                    if (sampleNow) begin
                        if (!rxSync)
                            frameErrPend <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    data        <= shiftReg;
                    parityError <= parityErrPend;
                    frameError  <= frameErrPend;
                    dataValid   <= 1'b1;
                    overrun     <= dataValid && !dataAck;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
